rotshift_seq: RTL and testbench
===============================

ROTSHIFT_SEQ -- requirements
Module: rotshift_seq

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width in bits, legal range 2..64.
- REQ-002 The block SHALL have parameter STEP, default 1: maximum bit positions moved per SHIFT cycle, legal range 1..WIDTH.
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
- REQ-004 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
- REQ-005 The block SHALL have port start, input, 1 bit: request; sampled on clk rising edge.
- REQ-006 The block SHALL have port op, input, 3 bits: 000 SHL, 001 SHR (logical), 010 SHRA (arithmetic), 011 ROL, 100 ROR; 101..111 illegal.
- REQ-007 The block SHALL have port din, input, WIDTH bits: operand.
- REQ-008 The block SHALL have port amt, input, $clog2(WIDTH) bits: shift/rotate amount; wider callers truncate upstream.
- REQ-009 The block SHALL have port result, output, WIDTH bits: working/final value.
- REQ-010 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
- REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
- REQ-012 The block SHALL have port cout, output, 1 bit: last bit moved out (shifts) or wrapped (rotates).
- REQ-013 The block SHALL have port err, output, 1 bit: illegal-op flag, valid with done.

Function
- REQ-014 The block SHALL implement states IDLE, SHIFT, DONE in a registered FSM.
- REQ-015 In IDLE or DONE with start=1, the block SHALL capture din into result, amt into a remaining-count register, and op into an op register on that edge.
- REQ-016 On capture with a legal op and amt>0, the next state SHALL be SHIFT; with amt=0 or an illegal op, the next state SHALL be DONE.
- REQ-017 Each SHIFT edge SHALL move result by s=min(STEP, remaining) positions per the captured op and SHALL decrement remaining by s.
- REQ-018 The block SHALL move from SHIFT to DONE on the edge where remaining reaches 0.
- REQ-019 Latency SHALL be 1+ceil(amt/STEP) edges from the start-sampling edge to DONE entry for legal op with amt>0, and 1 edge otherwise.
- REQ-020 DONE SHALL last exactly one cycle, then IDLE unless start=1 (back-to-back capture per REQ-015).
- REQ-021 start SHALL be ignored while in SHIFT; din, amt and op SHALL be don't-care outside the capture edge.
- REQ-022 SHL and SHR SHALL zero-fill; SHRA SHALL replicate the captured MSB; ROL and ROR SHALL wrap bits end-around.
- REQ-023 cout SHALL update on each SHIFT edge to the last bit shifted out or wrapped in that step, and SHALL be 0 after amt=0 or illegal-op capture.
- REQ-024 For an illegal op, result SHALL equal din unchanged and err SHALL be 1 during DONE; err SHALL clear on the next capture.
- REQ-025 result and cout SHALL hold their final values from DONE until the next capture.
- REQ-026 busy SHALL be high exactly when state is SHIFT; done SHALL be high exactly when state is DONE.
- REQ-027 The final result SHALL equal the single-step WIDTH-bit operation by amt for every legal op, amt, and STEP.

Reset
- REQ-028 Assertion of clr SHALL immediately force state IDLE, result 0, remaining 0, op register 000, busy 0, done 0, cout 0, err 0, regardless of clk, including mid-SHIFT.
- REQ-029 While clr is high, start SHALL be ignored; the first capture SHALL occur on the first rising edge with clr low and start=1.

Verification
- REQ-030 WIDTH=32, STEP=1, ROL, din=F2B80000, amt=2 -> busy for 2 cycles, done on the 3rd edge, result=CAE00003, cout=1.
- REQ-031 WIDTH=32, STEP=1, ROR, din=00000001, amt=1 -> result=80000000, cout=1; SHRA, din=80000000, amt=4 -> result=F8000000, cout=0.
- REQ-032 WIDTH=32, STEP=4, SHL, din=0000FFFF, amt=10 -> 3 SHIFT cycles, result=03FFFC00, cout=0; SHR same din, amt=0 -> done after 1 edge, result=0000FFFF, busy never high.
- REQ-033 op=110, din=12345678 -> done after 1 edge, err=1, result=12345678; the next legal capture clears err.
- REQ-034 clr asserted mid-SHIFT (ROL, amt=20, STEP=1) -> all outputs 0 asynchronously; start pulsed during SHIFT is ignored; start on the DONE cycle is captured back-to-back.
- REQ-035 A randomized run over all legal ops, amt 0..31, and STEP in {1,3,8,32} SHALL match a reference model on result and cout, and SHALL match the REQ-019 latency.

Source files
------------

// File: rtl/rotshift_seq_if.sv
// Request/response bundle for rotshift_seq: operands and start from the requester,
// working result and status flags back from the shifter.
interface rotshift_seq_if #(
    parameter int WIDTH = 32
) ();
    localparam int AW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             cout;
    logic             err;

    modport master (
        output start, op, din, amt,
        input  result, busy, done, cout, err
    );

    modport slave (
        input  start, op, din, amt,
        output result, busy, done, cout, err
    );
endinterface

// File: rtl/rotshift_seq.sv
// Multi-cycle shifter/rotator: moves the captured operand up to STEP positions per
// clock until the requested amount is consumed, then pulses done for one cycle.
//
// state | meaning
// IDLE  | waiting for start; result/cout/err hold the last outcome
// SHIFT | moving result by min(STEP, remaining) each edge; start ignored
// DONE  | one-cycle completion; start here captures back-to-back
module rotshift_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          clr,
    rotshift_seq_if.slave bus
);
    localparam int AW = $clog2(WIDTH);

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic [AW-1:0]      step_amt;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH:0]     sra_ext;
    logic [2*WIDTH-1:0] rol_dbl;
    logic [2*WIDTH-1:0] ror_dbl;
    logic               cap_legal;

    // STEP can exceed the remaining-count range, so compare in int before narrowing.
    always_comb begin
        if (int'(rem_q) > STEP) begin
            step_amt = AW'(STEP);
        end else begin
            step_amt = rem_q;
        end
    end

    // The extra bit on each shifted operand catches the last bit pushed out; the
    // doubled operand turns a rotate into a plain shift of one half.
    always_comb begin
        shl_ext = {1'b0, result_q} << step_amt;
        shr_ext = {result_q, 1'b0} >> step_amt;
        sra_ext = $unsigned($signed({result_q, 1'b0}) >>> step_amt);
        rol_dbl = {result_q, result_q} << step_amt;
        ror_dbl = {result_q, result_q} >> step_amt;
    end

    assign cap_legal = (bus.op <= OP_ROR);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        op_d     = op_q;
        cout_d   = cout_q;
        err_d    = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    result_d = bus.din;
                    rem_d    = bus.amt;
                    op_d     = bus.op;
                    cout_d   = 1'b0;
                    err_d    = !cap_legal;
                    if (cap_legal && (bus.amt != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                rem_d = rem_q - step_amt;
                case (op_q)
                    OP_SHL: begin
                        result_d = shl_ext[WIDTH-1:0];
                        cout_d   = shl_ext[WIDTH];
                    end
                    OP_SHR: begin
                        result_d = shr_ext[WIDTH:1];
                        cout_d   = shr_ext[0];
                    end
                    OP_SHRA: begin
                        result_d = sra_ext[WIDTH:1];
                        cout_d   = sra_ext[0];
                    end
                    OP_ROL: begin
                        result_d = rol_dbl[2*WIDTH-1:WIDTH];
                        cout_d   = shl_ext[WIDTH];
                    end
                    OP_ROR: begin
                        result_d = ror_dbl[WIDTH-1:0];
                        cout_d   = shr_ext[0];
                    end
                    default: begin
                        result_d = result_q;
                        cout_d   = 1'b0;
                    end
                endcase
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cout   = cout_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_rotshift_seq.sv
// Bench for rotshift_seq: five instances (STEP 1,3,4,8,32) driven in lockstep with
// directed vectors, hand-written clear/back-to-back sequences and a reference sweep.
module tb_rotshift_seq;
    localparam int NDUT = 5;

    function automatic int step_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            3:       return 8;
            default: return 32;
        endcase
    endfunction

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] din;
        logic [4:0]  amt;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start_r = 1'b0;
    logic [2:0]  op_r = 3'b000;
    logic [31:0] din_r = 32'h0;
    logic [4:0]  amt_r = 5'd0;

    logic [31:0]     res_w [NDUT];
    logic [NDUT-1:0] busy_w;
    logic [NDUT-1:0] done_w;
    logic [NDUT-1:0] cout_w;
    logic [NDUT-1:0] err_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        rotshift_seq_if #(.WIDTH(32)) bus ();
        assign bus.start = start_r;
        assign bus.op    = op_r;
        assign bus.din   = din_r;
        assign bus.amt   = amt_r;
        rotshift_seq #(.WIDTH(32), .STEP(step_of(g))) u_dut (
            .clk (clk),
            .clr (clr),
            .bus (bus)
        );
        assign res_w[g]  = bus.result;
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign cout_w[g] = bus.cout;
        assign err_w[g]  = bus.err;
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d(step=%0d): got %h want %h", name, k, step_of(k), got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk({tag, " result"}, k, res_w[k], 32'h0);
            chk({tag, " busy"}, k, 32'(busy_w[k]), 32'h0);
            chk({tag, " done"}, k, 32'(done_w[k]), 32'h0);
            chk({tag, " cout"}, k, 32'(cout_w[k]), 32'h0);
            chk({tag, " err"}, k, 32'(err_w[k]), 32'h0);
        end
    endtask

    function automatic int exp_lat(input int k, input logic [2:0] o, input logic [4:0] a);
        if (o <= 3'b100 && a != 5'd0) begin
            return 1 + (int'(a) + step_of(k) - 1) / step_of(k);
        end
        return 1;
    endfunction

    // One position at a time, recording the bit that leaves or wraps.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] d, input logic [4:0] a,
                                      output logic [31:0] r, output logic c);
        r = d;
        c = 1'b0;
        if (o > 3'b100) return;
        for (int i = 0; i < int'(a); i++) begin
            case (o)
                3'b000: begin c = r[31]; r = {r[30:0], 1'b0}; end
                3'b001: begin c = r[0];  r = {1'b0, r[31:1]}; end
                3'b010: begin c = r[0];  r = {r[31], r[31:1]}; end
                3'b011: begin c = r[31]; r = {r[30:0], r[31]}; end
                default: begin c = r[0]; r = {r[0], r[31:1]}; end
            endcase
        end
    endfunction

    task automatic run_vec(input string tag, input logic [2:0] v_op, input logic [31:0] v_din,
                           input logic [4:0] v_amt, input logic [31:0] e_res, input logic e_cout,
                           input logic e_err, input bit rel_clr);
        int lat [NDUT];
        int bcnt [NDUT];
        int dcnt [NDUT];
        logic [31:0] rs [NDUT];
        logic cs [NDUT];
        logic es [NDUT];
        int limit;
        int el;
        limit = int'(v_amt) + 4;
        for (int k = 0; k < NDUT; k++) begin
            lat[k] = 0; bcnt[k] = 0; dcnt[k] = 0; rs[k] = '0; cs[k] = 1'b0; es[k] = 1'b0;
        end
        @(negedge clk);
        op_r = v_op; din_r = v_din; amt_r = v_amt; start_r = 1'b1;
        if (rel_clr) clr = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (n == 1) start_r = 1'b0;
            for (int k = 0; k < NDUT; k++) begin
                if (done_w[k]) begin
                    dcnt[k]++;
                    if (lat[k] == 0) begin
                        lat[k] = n; rs[k] = res_w[k]; cs[k] = cout_w[k]; es[k] = err_w[k];
                    end
                end
                if (busy_w[k]) bcnt[k]++;
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            el = exp_lat(k, v_op, v_amt);
            chk({tag, " latency"}, k, 32'(lat[k]), 32'(el));
            chk({tag, " busy cycles"}, k, 32'(bcnt[k]), 32'(el - 1));
            chk({tag, " done pulses"}, k, 32'(dcnt[k]), 32'd1);
            chk({tag, " result"}, k, rs[k], e_res);
            chk({tag, " cout"}, k, 32'(cs[k]), 32'(e_cout));
            chk({tag, " err"}, k, 32'(es[k]), 32'(e_err));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [18];
        int n;
        bit got;
        logic [31:0] m_res;
        logic m_cout;

        vecs[0]  = '{3'b011, 32'hF2B80000, 5'd2,  32'hCAE00003, 1'b1, 1'b0};
        vecs[1]  = '{3'b100, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0};
        vecs[2]  = '{3'b010, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 32'h0000FFFF, 5'd10, 32'h03FFFC00, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 32'h0000FFFF, 5'd0,  32'h0000FFFF, 1'b0, 1'b0};
        vecs[5]  = '{3'b110, 32'h12345678, 5'd5,  32'h12345678, 1'b0, 1'b1};
        vecs[6]  = '{3'b001, 32'h0000FFFF, 5'd4,  32'h00000FFF, 1'b1, 1'b0};
        vecs[7]  = '{3'b000, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1'b0};
        vecs[8]  = '{3'b010, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{3'b010, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 32'h12345678, 5'd31, 32'h2468ACF0, 1'b0, 1'b0};
        vecs[11] = '{3'b011, 32'h12345678, 5'd4,  32'h23456781, 1'b1, 1'b0};
        vecs[12] = '{3'b000, 32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b1, 1'b0};
        vecs[13] = '{3'b111, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 1'b1};
        vecs[14] = '{3'b101, 32'h0F0F0F0F, 5'd31, 32'h0F0F0F0F, 1'b0, 1'b1};
        vecs[15] = '{3'b011, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[16] = '{3'b001, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
        vecs[17] = '{3'b100, 32'h0000000F, 5'd3,  32'hE0000001, 1'b1, 1'b0};

        #1 clr = 1'b1;
        #1 chk_zero("reset");
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].amt,
                    vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_err, 1'b0);
        end

        // Long ROL on the STEP=1 instance: stray start mid-SHIFT, then back-to-back capture.
        @(negedge clk);
        op_r = 3'b011; din_r = 32'h12345678; amt_r = 5'd20; start_r = 1'b1;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) start_r = 1'b0;
            if (n == 3) begin
                start_r = 1'b1; op_r = 3'b000; din_r = 32'hFFFFFFFF; amt_r = 5'd1;
            end
            if (n == 4) start_r = 1'b0;
            if (done_w[0]) got = 1'b1;
        end
        chk("ignore-start latency", 0, 32'(n), 32'd21);
        chk("ignore-start result", 0, res_w[0], 32'h67812345);
        chk("ignore-start cout", 0, 32'(cout_w[0]), 32'd1);
        op_r = 3'b001; din_r = 32'h000000F0; amt_r = 5'd5; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        chk("b2b busy", 0, 32'(busy_w[0]), 32'd1);
        chk("b2b done", 0, 32'(done_w[0]), 32'd0);
        n = 1;
        while (n < 40 && !done_w[0]) begin
            @(negedge clk);
            n++;
        end
        chk("b2b latency", 0, 32'(n), 32'd6);
        chk("b2b result", 0, res_w[0], 32'h00000007);
        chk("b2b cout", 0, 32'(cout_w[0]), 32'd1);
        repeat (3) @(negedge clk);

        // Asynchronous clear in the middle of a long shift, start held off while clr is high.
        op_r = 3'b011; din_r = 32'hFFFFFFFF; amt_r = 5'd20; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (4) @(negedge clk);
        #2 clr = 1'b1;
        #1 chk_zero("clr mid-shift");
        @(negedge clk);
        op_r = 3'b011; din_r = 32'h00000001; amt_r = 5'd3; start_r = 1'b1;
        @(negedge clk);
        chk_zero("clr held");
        run_vec("first after clr", 3'b011, 32'h00000001, 5'd3, 32'h00000008, 1'b0, 1'b0, 1'b1);

        for (int o = 0; o < 5; o++) begin
            for (int a = 0; a < 32; a++) begin
                ref_model(3'(o), 32'h9C3A5E71, 5'(a), m_res, m_cout);
                run_vec($sformatf("sweep op%0d amt%0d", o, a), 3'(o), 32'h9C3A5E71, 5'(a),
                        m_res, m_cout, 1'b0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
